mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
Load/store initiator for the MEM stage of the pipelined processor. It takes EX/MEM requests and drives the word-addressed data memory port (memread, memwrite, address, writedata, readdata). It supports byte, halfword and word accesses, sign- or zero-extends loads, and performs sub-word stores as a two-cycle read-modify-write while stalling the pipeline. Results go out on a registered MEM/WB interface.

Parameters:
DATA_W, 32, data word width
MEM_WORDS, 128, memory depth in words; word index width is clog2(MEM_WORDS) = 7

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_read  in  1  load request
req_write  in  1  store request
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
req_signed  in  1  sign-extend load
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
req_rd  in  5  destination register
req_regwrite  in  1  writeback enable from decode
memread  out  1  memory read strobe
memwrite  out  1  memory write strobe
address  out  32  word index = req_addr>>2, with upper bits zeroed above index width
writedata  out  32  word written to memory
readdata  in  32  memory read data, combinational from address
stall  out  1  hold EX/MEM register and upstream
wb_valid  out  1  registered: an access completed last cycle
wb_data  out  32  registered load result (0 for stores)
wb_rd  out  5  registered destination
wb_regwrite  out  1  registered: req_regwrite AND load AND NOT misaligned
misaligned  out  1  registered one-cycle fault pulse

Behaviour:
- FSM states: IDLE and MERGE. Reset puts the FSM in IDLE, sets all registered outputs to 0, and forces memread/memwrite to 0 in the reset cycle.
- Memory-side outputs are combinational from state and inputs. When idle with no request, memread=memwrite=0, address=0 and writedata=0.
- Alignment check: a half access with addr[0]=1 is misaligned. A word access with addr[1:0]!=0 is misaligned.
- Misaligned request: no memory strobe. Next cycle: misaligned=1, wb_valid=1, wb_regwrite=0, wb_data=0.
- Address bits above the index width are ignored, so addresses wrap modulo MEM_WORDS*4.
- If req_read and req_write are both set, the write wins and the read is ignored.
- Load, any size, in IDLE:
  - memread=1 in the same cycle, with no stall.
  - Select lane byte addr[1:0] or half addr[1], then extend per req_signed.
  - Register to wb_* on the next edge (latency 1).
- Word store in IDLE: memwrite=1 and writedata=req_wdata in the same cycle. No stall, with wb_valid the next cycle.
- Sub-word store in IDLE:
  - Cycle A: memread=1 and stall=1. Latch readdata, the word index, lane, size and wdata, then move to MERGE.
  - Cycle B (MERGE): memwrite=1 and writedata=latched word with the lane replaced; address is the latched index. stall=0, inputs are ignored, and the FSM returns to IDLE.
  - wb_valid is asserted the cycle after B.
- In MERGE, memread=0. A new request is only accepted back in IDLE.
- req_valid=0, or neither read nor write set: no strobes, and wb_valid=0 next cycle.
- Reset during MERGE: the write is abandoned, memwrite=0 that cycle, and the FSM returns to IDLE.
- wb_valid and misaligned are single-cycle pulses per completed access.

Decomposition:
- Package lsu_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF and SZ_WORD
  - the state enum {IDLE, MERGE}
  - the word index width constant
- One sub-module, lsu_lane, is natural. It is purely combinational and provides:
  - load extraction and extension from (word, addr[1:0], size, signed)
  - store merge of (old word, wdata, addr[1:0], size)

Test Plan:
(Memory preloaded with mem[i] = i*10.)
1. lw addr 0x14, rd=3: memread in the issue cycle with address=5. Next cycle wb_valid=1, wb_data=50, wb_rd=3, wb_regwrite=1, and stall stays 0.
2. lb addr 0x34 (mem[13]=0x82), signed: wb_data=0xFFFFFF82. The same access with lbu gives wb_data=0x00000082.
3. sh addr 0x0A, wdata 0x0000BEEF: cycle A has memread=1, stall=1 and address=2. Cycle B has memwrite=1 and writedata=0xBEEF0014. A follow-up lw 0x08 returns 0xBEEF0014.
4. lw addr 0x06: no memread or memwrite. Next cycle misaligned=1, wb_valid=1 and wb_regwrite=0.
5. sb addr 0x11, wdata 0xAA, with reset asserted in the MERGE cycle: memwrite stays 0 and mem[4] remains 40. The FSM is in IDLE and all wb_* outputs are 0 afterwards.
6. Back-to-back sw addr 0x20 with 7, then lw addr 0x20: one write cycle, then a read returning 7, with no stall in either cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the MEM-stage load/store unit.
package lsu_pkg;

    localparam int DATA_W    = 32;
    localparam int MEM_WORDS = 128;
    localparam int IDX_W     = $clog2(MEM_WORDS);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } lsu_state_t;

    // Bytes are always aligned; the reserved size code behaves like a word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = offset[0];
            default: is_misaligned = (offset != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: load extraction/extension and sub-word store merge.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] load_word,
    input  logic [1:0]  load_off,
    input  logic [1:0]  load_size,
    input  logic        load_signed,
    output logic [31:0] load_data,
    input  logic [31:0] old_word,
    input  logic [31:0] store_data,
    input  logic [1:0]  store_off,
    input  logic [1:0]  store_size,
    output logic [31:0] merged_word
);

    logic [7:0]  load_byte;
    logic [15:0] load_half;

    always_comb begin
        load_byte = load_word[{load_off, 3'b000} +: 8];
        load_half = load_word[{load_off[1], 4'b0000} +: 16];
        case (load_size)
            SZ_BYTE: load_data = {{24{load_signed & load_byte[7]}}, load_byte};
            SZ_HALF: load_data = {{16{load_signed & load_half[15]}}, load_half};
            default: load_data = load_word;
        endcase
    end

    always_comb begin
        merged_word = old_word;
        case (store_size)
            SZ_BYTE: merged_word[{store_off, 3'b000} +: 8]     = store_data[7:0];
            SZ_HALF: merged_word[{store_off[1], 4'b0000} +: 16] = store_data[15:0];
            default: merged_word = store_data;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store initiator; sub-word stores become a stalled read-modify-write.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [4:0]        req_rd,
    input  logic              req_regwrite,
    output logic              memread,
    output logic              memwrite,
    output logic [31:0]       address,
    output logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] readdata,
    output logic              stall,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [4:0]        wb_rd,
    output logic              wb_regwrite,
    output logic              misaligned
);

    localparam int WIDX = $clog2(MEM_WORDS);

    lsu_state_t state;
    logic [WIDX-1:0]   lat_idx;
    logic [1:0]        lat_off;
    logic [1:0]        lat_size;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] lat_word;
    logic [4:0]        lat_rd;

    logic            is_write, is_read, access, bad, sub_store;
    logic [WIDX-1:0] req_idx;
    logic [31:0]     load_data, merged_word;
    logic            unused_addr_bits;

    // A simultaneous read and write request is treated as a write.
    assign is_write  = req_valid & req_write;
    assign is_read   = req_valid & req_read & ~req_write;
    assign access    = is_write | is_read;
    assign bad       = access & is_misaligned(req_size, req_addr[1:0]);
    assign sub_store = is_write & ~bad & ((req_size == SZ_BYTE) | (req_size == SZ_HALF));
    assign req_idx   = req_addr[WIDX+1:2];
    assign unused_addr_bits = ^req_addr[31:WIDX+2];

    lsu_lane u_lane (
        .load_word   (readdata),
        .load_off    (req_addr[1:0]),
        .load_size   (req_size),
        .load_signed (req_signed),
        .load_data   (load_data),
        .old_word    (lat_word),
        .store_data  (lat_wdata),
        .store_off   (lat_off),
        .store_size  (lat_size),
        .merged_word (merged_word)
    );

    // Reset masks every strobe so an in-flight merge write is abandoned.
    always_comb begin
        memread   = 1'b0;
        memwrite  = 1'b0;
        address   = '0;
        writedata = '0;
        stall     = 1'b0;
        if (!reset) begin
            if (state == MERGE) begin
                memwrite  = 1'b1;
                address   = {{(32-WIDX){1'b0}}, lat_idx};
                writedata = merged_word;
            end else if (access && !bad) begin
                address = {{(32-WIDX){1'b0}}, req_idx};
                if (sub_store) begin
                    memread = 1'b1;
                    stall   = 1'b1;
                end else if (is_write) begin
                    memwrite  = 1'b1;
                    writedata = req_wdata;
                end else begin
                    memread = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            lat_idx     <= '0;
            lat_off     <= '0;
            lat_size    <= '0;
            lat_wdata   <= '0;
            lat_word    <= '0;
            lat_rd      <= '0;
            wb_valid    <= 1'b0;
            wb_data     <= '0;
            wb_rd       <= '0;
            wb_regwrite <= 1'b0;
            misaligned  <= 1'b0;
        end else begin
            wb_valid    <= 1'b0;
            wb_data     <= '0;
            wb_rd       <= '0;
            wb_regwrite <= 1'b0;
            misaligned  <= 1'b0;
            if (state == MERGE) begin
                state    <= IDLE;
                wb_valid <= 1'b1;
                wb_rd    <= lat_rd;
            end else if (sub_store) begin
                state     <= MERGE;
                lat_idx   <= req_idx;
                lat_off   <= req_addr[1:0];
                lat_size  <= req_size;
                lat_wdata <= req_wdata;
                lat_word  <= readdata;
                lat_rd    <= req_rd;
            end else if (access) begin
                wb_valid <= 1'b1;
                wb_rd    <= req_rd;
                if (bad) begin
                    misaligned <= 1'b1;
                end else if (is_read) begin
                    wb_data     <= load_data;
                    wb_regwrite <= req_regwrite;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu with a behavioural memory/access model.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_read, req_write, req_signed, req_regwrite;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        memread, memwrite, stall;
    logic [31:0] address, writedata, readdata;
    logic        wb_valid, wb_regwrite, misaligned;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;

    logic [31:0] ram       [0:127];
    logic [31:0] model_mem [0:127];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage_lsu dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_read     (req_read),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rd       (req_rd),
        .req_regwrite (req_regwrite),
        .memread      (memread),
        .memwrite     (memwrite),
        .address      (address),
        .writedata    (writedata),
        .readdata     (readdata),
        .stall        (stall),
        .wb_valid     (wb_valid),
        .wb_data      (wb_data),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .misaligned   (misaligned)
    );

    assign readdata = ram[address[6:0]];

    always @(posedge clk) begin
        if (memwrite) ram[address[6:0]] <= writedata;
    end

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % 128);
    endfunction

    function automatic logic model_mis(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return 1'b0;
        if (sz == 2'd1) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
        logic [31:0] word, val;
        word = model_mem[widx(a)];
        if (sz == 2'd0) begin
            val = (word >> (8 * (a % 4))) & 32'hFF;
            if (sg && val >= 32'd128) val = val | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            val = (word >> (16 * ((a % 4) / 2))) & 32'hFFFF;
            if (sg && val >= 32'd32768) val = val | 32'hFFFF_0000;
        end else begin
            val = word;
        end
        return val;
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] mask;
        int sh;
        mask = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
        sh   = (sz == 2'd0) ? 8 * int'(a % 4) : 16 * int'((a % 4) / 2);
        return (model_mem[widx(a)] & ~(mask << sh)) | ((wd & mask) << sh);
    endfunction

    task automatic drive(input logic v, input logic r, input logic w, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] rd, input logic rw);
        req_valid = v; req_read = r; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd; req_rd = rd; req_regwrite = rw;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 5'd3, 1'b1);
        #4;
        total++;
        if (memread !== 1'b0 || memwrite !== 1'b0 || stall !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_strobes: got rd=%b wr=%b stall=%b expected 0 0 0", memread, memwrite, stall);
        end
        next_cycle();
        next_cycle();
        total++;
        if ({wb_valid, wb_regwrite, misaligned} !== 3'b000 || wb_data !== 32'h0 || wb_rd !== 5'd0) begin
            bad++;
            $display("[TB] FAIL reset_wb: got v=%b rw=%b mis=%b data=%h rd=%0d expected all 0",
                     wb_valid, wb_regwrite, misaligned, wb_data, wb_rd);
        end
        reset = 1'b0;
        idle_inputs();
        #4;
        total++;
        if (memread !== 1'b0 || memwrite !== 1'b0 || address !== 32'h0 || writedata !== 32'h0) begin
            bad++;
            $display("[TB] FAIL idle_outputs: got rd=%b wr=%b addr=%h wdata=%h expected zeros",
                     memread, memwrite, address, writedata);
        end
        next_cycle();
    endtask

    task automatic test_load_word();
        drive(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 5'd3, 1'b1);
        #4;
        total++;
        if (memread !== 1'b1 || memwrite !== 1'b0 || address !== 32'd5 || stall !== 1'b0) begin
            bad++;
            $display("[TB] FAIL lw_issue: got rd=%b wr=%b addr=%0d stall=%b expected 1 0 5 0",
                     memread, memwrite, address, stall);
        end
        next_cycle();
        idle_inputs();
        total++;
        if (wb_valid !== 1'b1 || wb_data !== 32'd50 || wb_rd !== 5'd3 || wb_regwrite !== 1'b1 || misaligned !== 1'b0) begin
            bad++;
            $display("[TB] FAIL lw_result: got v=%b data=%0d rd=%0d rw=%b mis=%b expected 1 50 3 1 0",
                     wb_valid, wb_data, wb_rd, wb_regwrite, misaligned);
        end
        next_cycle();
        total++;
        if (wb_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL wb_pulse: got wb_valid=%b expected 0", wb_valid);
        end
    endtask

    task automatic test_load_byte();
        drive(1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 32'h34, 32'h0, 5'd7, 1'b1);
        next_cycle();
        drive(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 32'h34, 32'h0, 5'd8, 1'b1);
        total++;
        if (wb_data !== 32'hFFFF_FF82 || wb_rd !== 5'd7) begin
            bad++;
            $display("[TB] FAIL lb_signed: got data=%h rd=%0d expected ffffff82 7", wb_data, wb_rd);
        end
        next_cycle();
        idle_inputs();
        total++;
        if (wb_data !== 32'h0000_0082 || wb_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL lbu: got data=%h valid=%b expected 00000082 1", wb_data, wb_valid);
        end
        next_cycle();
    endtask

    task automatic test_store_half();
        drive(1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 32'h0A, 32'h0000_BEEF, 5'd0, 1'b0);
        #4;
        total++;
        if (memread !== 1'b1 || stall !== 1'b1 || address !== 32'd2 || memwrite !== 1'b0) begin
            bad++;
            $display("[TB] FAIL sh_cycle_a: got rd=%b stall=%b addr=%0d wr=%b expected 1 1 2 0",
                     memread, stall, address, memwrite);
        end
        next_cycle();
        drive(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 32'h40, 32'h1234_5678, 5'd9, 1'b1);
        #4;
        total++;
        if (memwrite !== 1'b1 || memread !== 1'b0 || stall !== 1'b0 || address !== 32'd2 || writedata !== 32'hBEEF_0014) begin
            bad++;
            $display("[TB] FAIL sh_cycle_b: got wr=%b rd=%b stall=%b addr=%0d wdata=%h expected 1 0 0 2 beef0014",
                     memwrite, memread, stall, address, writedata);
        end
        next_cycle();
        model_mem[2] = 32'hBEEF_0014;
        drive(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h08, 32'h0, 5'd4, 1'b1);
        total++;
        if (wb_valid !== 1'b1 || wb_regwrite !== 1'b0 || wb_data !== 32'h0) begin
            bad++;
            $display("[TB] FAIL sh_wb: got v=%b rw=%b data=%h expected 1 0 0", wb_valid, wb_regwrite, wb_data);
        end
        next_cycle();
        idle_inputs();
        total++;
        if (wb_data !== 32'hBEEF_0014) begin
            bad++;
            $display("[TB] FAIL sh_readback: got %h expected beef0014", wb_data);
        end
        next_cycle();
    endtask

    task automatic test_misaligned();
        drive(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h06, 32'h0, 5'd5, 1'b1);
        #4;
        total++;
        if (memread !== 1'b0 || memwrite !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mis_strobes: got rd=%b wr=%b expected 0 0", memread, memwrite);
        end
        next_cycle();
        idle_inputs();
        total++;
        if (misaligned !== 1'b1 || wb_valid !== 1'b1 || wb_regwrite !== 1'b0 || wb_data !== 32'h0) begin
            bad++;
            $display("[TB] FAIL mis_result: got mis=%b v=%b rw=%b data=%h expected 1 1 0 0",
                     misaligned, wb_valid, wb_regwrite, wb_data);
        end
        next_cycle();
        total++;
        if (misaligned !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mis_pulse: got %b expected 0", misaligned);
        end
    endtask

    task automatic test_reset_in_merge();
        drive(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AA, 5'd0, 1'b0);
        next_cycle();
        idle_inputs();
        reset = 1'b1;
        #4;
        total++;
        if (memwrite !== 1'b0) begin
            bad++;
            $display("[TB] FAIL merge_reset_wr: got memwrite=%b expected 0", memwrite);
        end
        next_cycle();
        reset = 1'b0;
        total++;
        if (ram[4] !== 32'd40 || {wb_valid, wb_regwrite, misaligned} !== 3'b000 || wb_data !== 32'h0 || wb_rd !== 5'd0) begin
            bad++;
            $display("[TB] FAIL merge_reset_state: got mem4=%0d v=%b rw=%b mis=%b data=%h rd=%0d expected 40 and zeros",
                     ram[4], wb_valid, wb_regwrite, misaligned, wb_data, wb_rd);
        end
        drive(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd6, 1'b1);
        #4;
        total++;
        if (memread !== 1'b1 || stall !== 1'b0 || memwrite !== 1'b0) begin
            bad++;
            $display("[TB] FAIL merge_reset_idle: got rd=%b stall=%b wr=%b expected 1 0 0", memread, stall, memwrite);
        end
        next_cycle();
        idle_inputs();
        total++;
        if (wb_data !== model_load(32'h10, 2'd2, 1'b0)) begin
            bad++;
            $display("[TB] FAIL merge_reset_data: got %0d expected %0d", wb_data, model_load(32'h10, 2'd2, 1'b0));
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'd7, 5'd0, 1'b0);
        #4;
        total++;
        if (memwrite !== 1'b1 || writedata !== 32'd7 || stall !== 1'b0 || memread !== 1'b0 || address !== 32'd8) begin
            bad++;
            $display("[TB] FAIL b2b_sw: got wr=%b wdata=%0d stall=%b rd=%b addr=%0d expected 1 7 0 0 8",
                     memwrite, writedata, stall, memread, address);
        end
        next_cycle();
        model_mem[8] = 32'd7;
        drive(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 5'd10, 1'b1);
        #4;
        total++;
        if (memread !== 1'b1 || stall !== 1'b0 || wb_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_lw_issue: got rd=%b stall=%b prev_valid=%b expected 1 0 1", memread, stall, wb_valid);
        end
        next_cycle();
        idle_inputs();
        total++;
        if (wb_data !== 32'd7 || wb_rd !== 5'd10 || wb_regwrite !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_lw_data: got data=%0d rd=%0d rw=%b expected 7 10 1", wb_data, wb_rd, wb_regwrite);
        end
        next_cycle();
    endtask

    task automatic test_random();
        logic        v, r, w, sg, rw, acc, wr, mis, sub;
        logic [1:0]  sz;
        logic [31:0] a, wd, exp_load, exp_merge;
        logic [4:0]  rd;
        for (int i = 0; i < 200; i++) begin
            v  = ($urandom_range(0, 7) != 0);
            r  = 1'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            if ($urandom_range(0, 2) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                else if (sz != 2'd0) a[1:0] = 2'b00;
            end
            wd = $urandom;
            rd = 5'($urandom_range(0, 31));
            rw = 1'($urandom_range(0, 1));
            acc = v && (r || w);
            wr  = v && w;
            mis = acc && model_mis(sz, a);
            sub = wr && !mis && (sz < 2'd2);
            exp_load = model_load(a, sz, sg);
            drive(v, r, w, sz, sg, a, wd, rd, rw);
            #4;
            total++;
            if (memread !== (acc && !mis && (!wr || sub)) || memwrite !== (wr && !mis && !sub) || stall !== sub) begin
                bad++;
                $display("[TB] FAIL rand_strobes[%0d]: got rd=%b wr=%b stall=%b expected %b %b %b", i,
                         memread, memwrite, stall, acc && !mis && (!wr || sub), wr && !mis && !sub, sub);
            end
            if (acc && !mis) begin
                total++;
                if (address !== 32'(widx(a))) begin
                    bad++;
                    $display("[TB] FAIL rand_addr[%0d]: got %0d expected %0d", i, address, widx(a));
                end
            end
            if (wr && !mis && !sub) begin
                total++;
                if (writedata !== wd) begin
                    bad++;
                    $display("[TB] FAIL rand_sw_data[%0d]: got %h expected %h", i, writedata, wd);
                end
                model_mem[widx(a)] = wd;
            end
            next_cycle();
            if (sub) begin
                exp_merge = model_merge(a, sz, wd);
                drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      1'b0, $urandom, $urandom, 5'd0, 1'b1);
                #4;
                total++;
                if (memwrite !== 1'b1 || memread !== 1'b0 || writedata !== exp_merge || address !== 32'(widx(a))) begin
                    bad++;
                    $display("[TB] FAIL rand_merge[%0d]: got wr=%b rd=%b wdata=%h addr=%0d expected 1 0 %h %0d", i,
                             memwrite, memread, writedata, address, exp_merge, widx(a));
                end
                model_mem[widx(a)] = exp_merge;
                next_cycle();
                total++;
                if (wb_valid !== 1'b1 || wb_regwrite !== 1'b0 || wb_data !== 32'h0 || misaligned !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL rand_merge_wb[%0d]: got v=%b rw=%b data=%h mis=%b expected 1 0 0 0", i,
                             wb_valid, wb_regwrite, wb_data, misaligned);
                end
            end else begin
                total++;
                if (wb_valid !== acc || misaligned !== mis) begin
                    bad++;
                    $display("[TB] FAIL rand_wb_flags[%0d]: got v=%b mis=%b expected %b %b", i,
                             wb_valid, misaligned, acc, mis);
                end
                if (acc && !mis && !wr) begin
                    total++;
                    if (wb_data !== exp_load || wb_rd !== rd || wb_regwrite !== rw) begin
                        bad++;
                        $display("[TB] FAIL rand_load[%0d]: got data=%h rd=%0d rw=%b expected %h %0d %b", i,
                                 wb_data, wb_rd, wb_regwrite, exp_load, rd, rw);
                    end
                end else if (acc) begin
                    total++;
                    if (wb_regwrite !== 1'b0 || wb_data !== 32'h0) begin
                        bad++;
                        $display("[TB] FAIL rand_nowb[%0d]: got rw=%b data=%h expected 0 0", i, wb_regwrite, wb_data);
                    end
                end
            end
        end
        idle_inputs();
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            ram[i]       = 32'(i * 10);
            model_mem[i] = 32'(i * 10);
        end
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        test_reset();
        test_load_word();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_reset_in_merge();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
